// File: rtl/hex_dump_tx_pkg.sv
// hex_dump_tx_pkg
// Shared definitions for the hex dump transmitter:
//   - FSM state encoding (IDLE / DIGIT / GAP / SEP / CR)
//   - ASCII constants for the separators and line terminator
//   - hexdigit(): 4-bit value to lowercase ASCII hex character
package hex_dump_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;  // waiting for a FIFO word
  localparam state_t DIGIT = 3'd1;  // emit next hex digit when UART ready
  localparam state_t GAP   = 3'd2;  // one-cycle guard after every strobe
  localparam state_t SEP   = 3'd3;  // emit space or first terminator char
  localparam state_t CR    = 3'd4;  // emit LF after CR (CRLF build only)

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  // 0-9 -> '0'-'9', 10-15 -> 'a'-'f'
  function automatic logic [7:0] hexdigit(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};  // 8'h57 = 'a' - 10
  endfunction

endpackage

// File: rtl/hex_dump_tx.sv
// hex_dump_tx
// Drains a capture FIFO and renders each word as lowercase ASCII hex for a
// logging UART. Words are separated by spaces; every PER_LINE-th word is
// followed by a line terminator instead. Every character strobe is followed
// by a one-cycle guard so the UART can drop uart_ready after acceptance.
//
// Parameters:
//   WIDTH    FIFO word width (multiple of 4, 4..64)
//   PER_LINE words per output line (1..255)
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-low reset
//   fifo_available   FIFO non-empty
//   fifo_data        FIFO head word
//   fifo_read_strobe one-cycle pop pulse, the cycle after a word is captured
//   uart_ready       UART may accept a byte
//   uart_strobe      one-cycle pulse, uart_data is to be sent
//   uart_data        ASCII character (holds between strobes)
//   busy             high from word capture until its last character is sent
//
// Build option: define HEX_DUMP_TX_CRLF_EN to terminate lines with CR LF
// instead of LF alone.
module hex_dump_tx
  import hex_dump_tx_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PER_LINE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_available,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_strobe,
  input  logic             uart_ready,
  output logic             uart_strobe,
  output logic [7:0]       uart_data,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int NCW = $clog2(NIB + 1);
  localparam logic [NCW-1:0] NIB_INIT  = NCW'(NIB);
  localparam logic [NCW-1:0] NIB_ONE   = NCW'(1);
  localparam logic [7:0]     LAST_WORD = 8'(PER_LINE - 1);

  state_t           state_q, state_d;
  state_t           gap_ret_q, gap_ret_d;  // where GAP goes next
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [NCW-1:0]   nib_cnt_q, nib_cnt_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             rd_stb_q, rd_stb_d;
  logic             uart_stb_q, uart_stb_d;
  logic [7:0]       uart_data_q, uart_data_d;
  logic             busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gap_ret_q   <= IDLE;
      shift_q     <= '0;
      nib_cnt_q   <= '0;
      word_cnt_q  <= '0;
      rd_stb_q    <= 1'b0;
      uart_stb_q  <= 1'b0;
      uart_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_ret_q   <= gap_ret_d;
      shift_q     <= shift_d;
      nib_cnt_q   <= nib_cnt_d;
      word_cnt_q  <= word_cnt_d;
      rd_stb_q    <= rd_stb_d;
      uart_stb_q  <= uart_stb_d;
      uart_data_q <= uart_data_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_available) state_d = DIGIT;
      DIGIT:   if (uart_ready)     state_d = GAP;
      GAP:                         state_d = gap_ret_q;
      SEP:     if (uart_ready)     state_d = GAP;
      CR:      if (uart_ready)     state_d = GAP;
      default:                     state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    gap_ret_d   = gap_ret_q;
    shift_d     = shift_q;
    nib_cnt_d   = nib_cnt_q;
    word_cnt_d  = word_cnt_q;
    rd_stb_d    = 1'b0;
    uart_stb_d  = 1'b0;
    uart_data_d = uart_data_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (fifo_available) begin
          shift_d   = fifo_data;
          nib_cnt_d = NIB_INIT;
          busy_d    = 1'b1;
          rd_stb_d  = 1'b1;  // pop lands the cycle after capture
        end
      end
      DIGIT: begin
        if (uart_ready) begin
          uart_data_d = hexdigit(shift_q[WIDTH-1 -: 4]);
          uart_stb_d  = 1'b1;
          shift_d     = shift_q << 4;
          nib_cnt_d   = nib_cnt_q - NIB_ONE;
          // Last digit of the word: the guard cycle leads to the separator.
          gap_ret_d   = (nib_cnt_q == NIB_ONE) ? SEP : DIGIT;
        end
      end
      GAP: begin
        if (gap_ret_q == IDLE) busy_d = 1'b0;
      end
      SEP: begin
        if (uart_ready) begin
          uart_stb_d = 1'b1;
          gap_ret_d  = IDLE;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
`ifdef HEX_DUMP_TX_CRLF_EN
            uart_data_d = ASCII_CR;
            gap_ret_d   = CR;  // LF follows after its own guard cycle
`else
            uart_data_d = ASCII_LF;
`endif
          end else begin
            uart_data_d = ASCII_SPACE;
            word_cnt_d  = word_cnt_q + 8'd1;
          end
        end
      end
      CR: begin
        // Second half of the CR LF terminator; unreachable in the LF-only build.
        if (uart_ready) begin
          uart_data_d = ASCII_LF;
          uart_stb_d  = 1'b1;
          gap_ret_d   = IDLE;
        end
      end
      default: begin
        gap_ret_d = IDLE;
      end
    endcase
  end

  assign fifo_read_strobe = rd_stb_q;
  assign uart_strobe      = uart_stb_q;
  assign uart_data        = uart_data_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_hex_dump_tx.sv
// Bench for hex_dump_tx: two instances (WIDTH=32/PER_LINE=2 and
// WIDTH=8/PER_LINE=1), each fed from a queue-based FIFO model and a UART
// ready model, with the emitted character stream compared against a text
// rendering of the pushed words.
module tb_hex_dump_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       fav[2];
  logic [31:0] fdat_a;
  logic [7:0]  fdat_b;
  logic       frd[2];
  logic       urdy[2];
  logic       ustb[2];
  logic [7:0] udata[2];
  logic       busy[2];

  int checks = 0;
  int errors = 0;

  logic [63:0] fifo_q[2][$];
  logic [7:0]  got_q[2][$];
  logic [7:0]  exp_q[2][$];

  int mcnt[2];       // model: words already on the current line
  int rmode[2];      // 0 ready=1, 1 drop 10 cycles after strobe, 2 random
  int rhold[2];
  int rd_cnt[2];
  int stb_cnt[2];
  int busy_rise[2];
  int viol[2];
  logic prev_stb[2];
  logic prev_busy[2];

  always #5 clk = ~clk;

  hex_dump_tx #(.WIDTH(32), .PER_LINE(2)) u_a (
    .clk(clk), .reset(reset),
    .fifo_available(fav[0]), .fifo_data(fdat_a), .fifo_read_strobe(frd[0]),
    .uart_ready(urdy[0]), .uart_strobe(ustb[0]), .uart_data(udata[0]),
    .busy(busy[0])
  );

  hex_dump_tx #(.WIDTH(8), .PER_LINE(1)) u_b (
    .clk(clk), .reset(reset),
    .fifo_available(fav[1]), .fifo_data(fdat_b), .fifo_read_strobe(frd[1]),
    .uart_ready(urdy[1]), .uart_strobe(ustb[1]), .uart_data(udata[1]),
    .busy(busy[1])
  );

  function automatic int nib_of(int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic int per_line_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // FIFO / UART environment, updated on the falling edge
  initial begin
    logic [63:0] head;
    logic [63:0] tmp;
    for (int k = 0; k < 2; k++) begin
      fav[k] = 1'b0; urdy[k] = 1'b1; prev_stb[k] = 1'b0; prev_busy[k] = 1'b0;
    end
    fdat_a = '0;
    fdat_b = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          if (ustb[k]) begin
            got_q[k].push_back(udata[k]);
            stb_cnt[k]++;
            if (prev_stb[k] || !urdy[k] || !busy[k]) viol[k]++;
          end
          if (frd[k]) begin
            rd_cnt[k]++;
            if (!busy[k]) viol[k]++;
            if (fifo_q[k].size() > 0) tmp = fifo_q[k].pop_front();
          end
          if (busy[k] && !prev_busy[k]) busy_rise[k]++;
        end
        prev_stb[k]  = ustb[k];
        prev_busy[k] = busy[k];
        fav[k] = (fifo_q[k].size() > 0);
        head = (fifo_q[k].size() > 0) ? fifo_q[k][0] : 64'h0;
        if (k == 0) fdat_a = head[31:0];
        else        fdat_b = head[7:0];
        case (rmode[k])
          0: urdy[k] = 1'b1;
          1: begin
            if (ustb[k]) rhold[k] = 10;
            if (rhold[k] > 0) begin
              urdy[k] = 1'b0;
              rhold[k]--;
            end else begin
              urdy[k] = 1'b1;
            end
          end
          default: urdy[k] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push a word into the FIFO model and append its rendering to the
  // expected stream: NIB lowercase hex digits then space or terminator.
  task automatic push(int k, logic [63:0] w);
    logic [63:0] m;
    string s;
    m = (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
    w = w & m;
    fifo_q[k].push_back(w);
    s = $sformatf("%016x", w);
    for (int i = 16 - nib_of(k); i < 16; i++) exp_q[k].push_back(s[i]);
    if (mcnt[k] == per_line_of(k) - 1) begin
`ifdef HEX_DUMP_TX_CRLF_EN
      exp_q[k].push_back(8'h0D);
`endif
      exp_q[k].push_back(8'h0A);
      mcnt[k] = 0;
    end else begin
      exp_q[k].push_back(8'h20);
      mcnt[k]++;
    end
  endtask

  // Wait for the instance to finish, then compare the captured stream.
  task automatic drain(int k, int budget, string tag);
    int n;
    n = 0;
    while (n < budget && !(fifo_q[k].size() == 0 && !busy[k] &&
                           got_q[k].size() >= exp_q[k].size())) begin
      cyc(1);
      n++;
    end
    chk({tag, "_done"}, 64'(n < budget), 64'd1);
    cyc(4);
    chk({tag, "_len"}, 64'(got_q[k].size()), 64'(exp_q[k].size()));
    for (int i = 0; i < got_q[k].size() && i < exp_q[k].size(); i++)
      chk($sformatf("%s_ch%0d", tag, i), 64'(got_q[k][i]), 64'(exp_q[k][i]));
    $display("txn %s inst=%0d chars=%0d", tag, k, got_q[k].size());
    got_q[k].delete();
    exp_q[k].delete();
  endtask

  initial begin
    int s0, r0, b0, n;
    reset = 1'b0;
    cyc(3);
    for (int k = 0; k < 2; k++) begin
      chk("rst_stb", 64'(ustb[k]), 64'd0);
      chk("rst_rd", 64'(frd[k]), 64'd0);
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_data", 64'(udata[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Empty FIFO: nothing happens
    cyc(100);
    for (int k = 0; k < 2; k++) begin
      chk("idle_stb", 64'(stb_cnt[k]), 64'd0);
      chk("idle_rd", 64'(rd_cnt[k]), 64'd0);
      chk("idle_busy", 64'(busy_rise[k]), 64'd0);
    end

    // Two words, ready tied high: one full line
    rmode[0] = 0;
    r0 = rd_cnt[0];
    push(0, 64'hDEADBEEF);
    push(0, 64'h0123ABCD);
    drain(0, 400, "a_dir");
    chk("a_dir_rd", 64'(rd_cnt[0] - r0), 64'd2);
    chk("a_dir_proto", 64'(viol[0]), 64'd0);

    // Narrow word with slow UART: busy held over the whole word
    rmode[1] = 1;
    b0 = busy_rise[1];
    s0 = stb_cnt[1];
    push(1, 64'h5A);
    drain(1, 600, "b_slow");
    chk("b_slow_busy", 64'(busy_rise[1] - b0), 64'd1);
    chk("b_slow_proto", 64'(viol[1]), 64'd0);

    // Terminator length on a PER_LINE=1 instance
    rmode[1] = 0;
    s0 = stb_cnt[1];
    push(1, 64'hF0);
    drain(1, 200, "b_term");
`ifdef HEX_DUMP_TX_CRLF_EN
    chk("b_term_stb", 64'(stb_cnt[1] - s0), 64'd4);
`else
    chk("b_term_stb", 64'(stb_cnt[1] - s0), 64'd3);
`endif

    // Reset in the middle of a word that sits mid-line
    rmode[0] = 0;
    push(0, 64'($urandom));
    drain(0, 400, "a_pre");
    push(0, 64'h12345678);
    n = 0;
    while (got_q[0].size() < 3 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("mid_reach", 64'(n < 200), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_stb", 64'(ustb[0]), 64'd0);
    chk("mid_data", 64'(udata[0]), 64'd0);
    chk("mid_busy", 64'(busy[0]), 64'd0);
    chk("mid_rd", 64'(frd[0]), 64'd0);
    chk("mid_popped", 64'(fifo_q[0].size()), 64'd0);
    got_q[0].delete();
    exp_q[0].delete();
    mcnt[0] = 0;
    mcnt[1] = 0;
    cyc(3);
    @(negedge clk);
    reset = 1'b1;
    s0 = stb_cnt[0];
    cyc(30);
    chk("post_rst_quiet", 64'(stb_cnt[0] - s0), 64'd0);
    chk("post_rst_busy", 64'(busy[0]), 64'd0);
    push(0, 64'($urandom));
    drain(0, 400, "a_fresh");

    // FIFO continuously non-empty: busy still drops between words
    rmode[0] = 2;
    b0 = busy_rise[0];
    r0 = rd_cnt[0];
    for (int i = 0; i < 3; i++) push(0, 64'($urandom));
    drain(0, 2000, "a_cont");
    chk("a_cont_busy", 64'(busy_rise[0] - b0), 64'd3);
    chk("a_cont_rd", 64'(rd_cnt[0] - r0), 64'd3);

    // Random soak on both instances concurrently
    rmode[0] = 2;
    rmode[1] = 2;
    for (int i = 0; i < 20; i++) begin
      push(0, 64'($urandom));
      push(1, 64'($urandom));
    end
    drain(0, 6000, "a_rand");
    drain(1, 3000, "b_rand");

    chk("proto_a", 64'(viol[0]), 64'd0);
    chk("proto_b", 64'(viol[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_dump_tx.md
Name: hex_dump_tx

Overview:
- Drains a byte/word capture FIFO and renders each entry as ASCII hex text for the serial logging UART.
- Sits between the capture FIFO read side (data_available / read_data / read_strobe) and the UART transmitter strobe/ready input.
- Groups words into lines: space-separated, newline-terminated.
- Used to stream SPI capture words to the host as human-readable text.

Parameters:
- WIDTH, 32, FIFO word width in bits; must be a multiple of 4, range 4..64.
- PER_LINE, 8, words per output line; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- fifo_available  in  1  FIFO non-empty
- fifo_data  in  WIDTH  FIFO head word, valid while fifo_available=1
- fifo_read_strobe  out  1  one-cycle pop pulse to FIFO
- uart_ready  in  1  UART transmitter idle, may accept a byte
- uart_strobe  out  1  one-cycle pulse: uart_data is to be sent
- uart_data  out  8  ASCII character to send
- busy  out  1  high from word capture until its last character is strobed

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state=IDLE; word counter=0; shift register=0.
- All outputs are registered. NIB = WIDTH/4. Word counter width = 8 bits.
- IDLE:
  - If fifo_available=1: latch fifo_data into the shift register, set nibble count=NIB, busy<=1, go to DIGIT.
  - fifo_read_strobe is pulsed high in the cycle after capture, exactly one cycle per word, never while in IDLE.
- DIGIT:
  - When uart_ready=1: uart_data<=hexdigit(shift[WIDTH-1:WIDTH-4]) in lowercase a-f; uart_strobe<=1; shift left by 4; decrement nibble count; go to GAP.
- GAP:
  - One-cycle guard with no strobe, so uart_ready can deassert after acceptance. No back-to-back strobes ever.
  - Next state: DIGIT if nibble count≠0, else SEP.
- SEP: when uart_ready=1, strobe one separator character, then go through GAP.
  - If word counter==PER_LINE-1: send 0x0A (newline), word counter<=0.
  - Otherwise: send 0x20 (space), word counter+1.
  - After the separator's GAP: go to IDLE, busy<=0.
- Latency: FIFO word present in IDLE → first uart_strobe ≥2 cycles later (capture, then DIGIT with ready).
- Throughput: one character per 2 cycles maximum; NIB+1 characters per word.
- uart_ready low stalls DIGIT/SEP indefinitely; no timeout; no characters dropped.
- Empty FIFO: stays in IDLE; no strobes; partial line stays open (no flush).
- PER_LINE=1: every word is followed by newline; never space.
- fifo_available toggling mid-word is ignored; the next word is sampled only in IDLE.
- Reset mid-word: character output aborts immediately; the partially printed word and line are lost. The popped word is not re-read.
- uart_data holds its last value between strobes.

Optional Feature:
- Macro HEX_DUMP_TX_CRLF_EN.
- Defined: the line terminator is two characters, 0x0D then 0x0A, each strobed via its own SEP/GAP pair (extra CR sub-state). Word ending a line emits NIB+2 characters.
- Undefined: terminator is 0x0A only.
- Space separator is identical in both builds.

Decomposition:
- Shared utility package holds:
  - hexdigit function (4-bit → lowercase ASCII);
  - ASCII constants (SPACE 0x20, LF 0x0A, CR 0x0D);
  - state encoding localparams IDLE/DIGIT/GAP/SEP/CR.
- No sub-module; single FSM plus a shift register and two counters. The nibble-to-ASCII step is the package function, not an instance.

Test Plan:
- WIDTH=32, PER_LINE=2; FIFO holds 0xDEADBEEF, 0x0123ABCD; uart_ready tied 1 → exact byte stream "deadbeef 0123abcd\n". Exactly 2 fifo_read_strobe pulses; strobes never adjacent.
- WIDTH=8, PER_LINE=1; word 0x5A; uart_ready drops 10 cycles after each strobe → "5a\n". No strobe while ready=0. busy high throughout.
- Empty FIFO for 100 cycles after reset → uart_strobe, fifo_read_strobe, busy all 0.
- Assert reset=0 after the 3rd character of 0x12345678 → outputs 0 asynchronously. After release with FIFO empty: no further characters. Next word starts a fresh line (counter=0).
- With HEX_DUMP_TX_CRLF_EN, PER_LINE=1, word 0xFFFF0000 → "ffff0000\r\n" (10 strobes). Without the macro → 9 strobes ending 0x0A.
- FIFO non-empty continuously with 3 words, PER_LINE=8 → "xxxxxxxx " ×3, no newline. busy deasserts between words for ≥1 cycle in IDLE.
